muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for signed 32-bit multiply and divide in the multicycle CPU. It accepts a start pulse from the main control FSM, iterates a shift-add Booth multiplier or a restoring divider over latched operands, and writes the HI/LO result registers. It signals divide-by-zero to the exception path. The main FSM holds in a wait state until `done`.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_ctrl_if.sv | 24 ++
 rtl/muldiv_step.sv | 52 +++++
 rtl/muldiv_ctrl.sv | 132 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide sequencer
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_SIGN,
        S_DONE
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to unsigned 2^31.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - request/result bundle between the main control FSM and muldiv_ctrl
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_0, hi, lo
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_0, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational Booth (MULT) or restoring-division (DIV) iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             qm1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_n,
    output logic [WIDTH-1:0] q_n,
    output logic             qm1_n
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] r;
    logic [WIDTH:0] d;

    // The accumulator carries one guard bit so that subtracting the most
    // negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        acc_n = acc;
        q_n   = q;
        qm1_n = qm1;
        sum   = acc;
        r     = '0;
        d     = '0;
        if (op == OP_MULT) begin
            case ({q[0], qm1})
                2'b01:   sum = acc + {m[WIDTH-1], m};
                2'b10:   sum = acc - {m[WIDTH-1], m};
                default: sum = acc;
            endcase
            acc_n = {sum[WIDTH], sum[WIDTH:1]};
            q_n   = {sum[0], q[WIDTH-1:1]};
            qm1_n = q[0];
        end else begin
            r = {acc[WIDTH-1:0], q[WIDTH-1]};
            d = r - {1'b0, m};
            if (!d[WIDTH]) begin
                acc_n = {1'b0, d[WIDTH-1:0]};
                q_n   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = {1'b0, r[WIDTH-1:0]};
                q_n   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle signed multiply/divide sequencer writing HI/LO
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);

    state_t           state, state_n;
    logic [4:0]       cnt;
    logic             op_q, a_neg, b_neg, qm1_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q, m_q, hi_q, lo_q;
    logic             done_q, div0_q, busy_q;

    logic [WIDTH:0]   acc_n;
    logic [WIDTH-1:0] q_n;
    logic             qm1_n;
    logic             load, step, wr_mult, wr_div, last, div0_n;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op    (op_q),
        .acc   (acc_q),
        .q     (q_q),
        .qm1   (qm1_q),
        .m     (m_q),
        .acc_n (acc_n),
        .q_n   (q_n),
        .qm1_n (qm1_n)
    );

    assign last   = (cnt == 5'(ITER - 1));
    assign div0_n = load && (bus.op == OP_DIV) && (bus.b_in == '0);

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        wr_mult = 1'b0;
        wr_div  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    load = 1'b1;
                    if (bus.op == OP_MULT)    state_n = S_MULT;
                    else if (bus.b_in == '0)  state_n = S_DONE;
                    else                      state_n = S_DIV;
                end
            end
            S_MULT: begin
                step = 1'b1;
                if (last) begin
                    wr_mult = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DIV: begin
                step = 1'b1;
                if (last) state_n = S_SIGN;
            end
            S_SIGN: begin
                wr_div  = 1'b1;
                state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= OP_MULT;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            qm1_q  <= 1'b0;
            acc_q  <= '0;
            q_q    <= '0;
            m_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n != S_IDLE);
            done_q <= (state_n == S_DONE);
            div0_q <= div0_n;
            if (load) begin
                op_q  <= bus.op;
                a_neg <= bus.a_in[WIDTH-1];
                b_neg <= bus.b_in[WIDTH-1];
                cnt   <= '0;
                acc_q <= '0;
                qm1_q <= 1'b0;
                if (bus.op == OP_MULT) begin
                    q_q <= bus.b_in;
                    m_q <= bus.a_in;
                end else begin
                    q_q <= magnitude(bus.a_in);
                    m_q <= magnitude(bus.b_in);
                end
            end else if (step) begin
                acc_q <= acc_n;
                q_q   <= q_n;
                qm1_q <= qm1_n;
                cnt   <= cnt + 5'd1;
            end
            if (wr_mult) begin
                hi_q <= acc_n[WIDTH-1:0];
                lo_q <= q_n;
            end
            if (wr_div) begin
                lo_q <= (a_neg ^ b_neg) ? -q_q : q_q;
                hi_q <= a_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.div_0 = div0_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    muldiv_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: {writes_hilo, div_0, hi, lo} from native 64-bit arithmetic.
    function automatic logic [65:0] ref_op(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, qt, rm;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 1'b0) begin
            p = sa * sb;
            v = p;
            return {2'b10, v};
        end
        if (b == 32'h0) return {2'b01, 64'h0};
        qt = sa / sb;
        rm = sa % sb;
        v  = {rm[31:0], qt[31:0]};
        return {2'b10, v};
    endfunction

    function automatic int lat_of(input logic op, input logic [31:0] b);
        if (op == 1'b0) return 33;
        return (b == 32'h0) ? 1 : 34;
    endfunction

    logic        m_active = 1'b0, m_wr = 1'b0, m_pdiv0 = 1'b0;
    int          m_age = 0, m_lat = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    logic [65:0] m_next;

    assign m_next = ref_op(bus.op, bus.a_in, bus.b_in);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_hi     <= 32'h0;
            m_lo     <= 32'h0;
        end else if (m_active) begin
            if (m_age == m_lat) begin
                m_active <= 1'b0;
                if (m_wr) begin
                    m_hi <= m_phi;
                    m_lo <= m_plo;
                end
            end else begin
                m_age <= m_age + 1;
            end
        end else if (bus.start === 1'b1) begin
            m_active <= 1'b1;
            m_age    <= 1;
            m_lat    <= lat_of(bus.op, bus.b_in);
            m_wr     <= m_next[65];
            m_pdiv0  <= m_next[64];
            m_phi    <= m_next[63:32];
            m_plo    <= m_next[31:0];
        end
    end

    logic        e_done, e_div0;
    logic [31:0] e_hi, e_lo;
    assign e_done = m_active && (m_age == m_lat);
    assign e_div0 = e_done && m_pdiv0;
    assign e_hi   = (e_done && m_wr) ? m_phi : m_hi;
    assign e_lo   = (e_done && m_wr) ? m_plo : m_lo;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  {31'b0, bus.busy},  {31'b0, m_active});
            check("done",  {31'b0, bus.done},  {31'b0, e_done});
            check("div_0", {31'b0, bus.div_0}, {31'b0, e_div0});
            check("hi",    bus.hi, e_hi);
            check("lo",    bus.lo, e_lo);
            if (bus.done === 1'b1) n_done++;
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_d0, input int exp_lat, input string name);
        int   cyc;
        logic seen;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.b_in = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 60) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                bus.a_in  = $urandom;
                bus.b_in  = $urandom;
                bus.op    = 1'($urandom_range(0, 1));
                bus.start = (cyc == 5);
            end
        end
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
        check({name, "_div0"}, {31'b0, bus.div_0}, {31'b0, exp_d0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;
        bus.start = 1'b0; bus.op = 1'b0; bus.a_in = 32'h0; bus.b_in = 32'h0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'b0, bus.busy}, 32'h0);
        check("reset_done", {31'b0, bus.done}, 32'h0);
        check("reset_hi", bus.hi, 32'h0);
        check("reset_lo", bus.lo, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_op(1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, "mult_7xm3");
        run_op(1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, "mult_min_min");
        run_op(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0, 33, "mult_m1_m1");
        run_op(1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, "div_m7_2");
        run_op(1'b1, 32'd7,          32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 1'b0, 34, "div_7_m2");
        run_op(1'b0, 32'd3,          32'd5,         32'h0,         32'd15,        1'b0, 33, "mult_3x5");
        run_op(1'b1, 32'd9,          32'h0,         32'h0,         32'd15,        1'b1, 1,  "div_by_zero");
        run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 34, "div_min_m1");

        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 32'h1234_5678; bus.b_in = 32'h9ABC_DEF0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            bus.start = (c == 5);
            bus.op    = 1'b1;
        end
        bus.start = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'h0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_op(1'b0, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 33, "mult_2x3");

        n_before = n_done;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.start = ($urandom_range(0, 7) == 0);
            bus.op    = 1'($urandom_range(0, 1));
            bus.a_in  = pick();
            bus.b_in  = pick();
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        check("random_ops_completed", {31'b0, (n_done - n_before) >= 20}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
